gyrator_dt: RTL



---
 rtl/gyrator_pkg.sv | 30 +++
 rtl/gyrator_dt_if.sv | 31 +++
 rtl/gyr_mac_sat.sv | 36 +++
 rtl/gyrator_dt.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/gyrator_pkg.sv
// Shared types and helpers for the gyrator_dt block: FSM state encoding,
// the power-on gyration resistance and a width-parametrised saturator.
package gyrator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Gyration resistance after reset, in whole ohms (scaled by 2^R_FRAC at use).
  localparam int unsigned R_RESET_OHM = 50;

  // Clip a wide signed value into the signed range of a w-bit word.
  // The result stays 64 bits wide; callers keep the low w bits.
  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] x,
                                                 input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)
      sat_fn = hi;
    else if (x < lo)
      sat_fn = lo;
    else
      sat_fn = x;
  endfunction

endpackage

// File: rtl/gyrator_dt_if.sv
// Frame and configuration bus of gyrator_dt: input frame valid/ready,
// output frame valid/ready, resistance load and the busy indication.
// master = producer/consumer side, slave = the gyrator block.
interface gyrator_dt_if #(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 16,
  parameter int R_W      = 16,
  parameter int OUT_W    = 16
);

  logic                         r_load;
  logic [R_W-1:0]               r_in;
  logic                         in_valid;
  logic                         in_ready;
  logic [2*CHANNELS*IN_W-1:0]   in_i;
  logic                         out_valid;
  logic                         out_ready;
  logic [2*CHANNELS*OUT_W-1:0]  out_v;
  logic                         busy;

  modport master (
    output r_load, r_in, in_valid, in_i, out_ready,
    input  in_ready, out_valid, out_v, busy
  );

  modport slave (
    input  r_load, r_in, in_valid, in_i, out_ready,
    output in_ready, out_valid, out_v, busy
  );

endinterface

// File: rtl/gyr_mac_sat.sv
// Single shared arithmetic lane: signed current times unsigned resistance,
// floor shift by R_FRAC, optional negate, then saturate to OUT_W.
// Purely combinational; the parent registers the result.
module gyr_mac_sat
  import gyrator_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int R_W    = 16,
  parameter int R_FRAC = 4,
  parameter int OUT_W  = 16
) (
  input  logic signed [IN_W-1:0]  cur,
  input  logic        [R_W-1:0]   r,
  input  logic                    neg,
  output logic signed [OUT_W-1:0] v,
  output logic                    sat
);

  localparam int P_W = IN_W + R_W + 1;

  logic signed [P_W-1:0] prod;
  logic signed [63:0]    scaled;
  logic signed [63:0]    signed_val;
  logic signed [63:0]    clipped;

  // Multiply, floor-shift, negate after the shift, then clip and flag clipping.
  always_comb begin
    prod       = P_W'(cur) * P_W'($signed({1'b0, r}));
    scaled     = 64'(prod >>> R_FRAC);
    signed_val = neg ? -scaled : scaled;
    clipped    = sat_fn(signed_val, OUT_W);
    v          = clipped[OUT_W-1:0];
    sat        = (clipped != signed_val);
  end

endmodule

// File: rtl/gyrator_dt.sv
// Multi-channel discrete-time ideal gyrator: v1 = -R*i2, v2 = +R*i1.
// One shared multiplier walks the 2*CHANNELS output slices, one per cycle.
// Optional macro GYRATOR_OVF_STICKY_EN adds a sticky saturation flag
// (ovf) with a clear input (ovf_clr).
module gyrator_dt
  import gyrator_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IN_W     = 16,
  parameter int R_W      = 16,
  parameter int R_FRAC   = 4,
  parameter int OUT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef GYRATOR_OVF_STICKY_EN
  input  logic        ovf_clr,
  output logic        ovf,
`endif
  gyrator_dt_if.slave bus
);

  localparam int N_SL  = 2 * CHANNELS;
  localparam int IDX_W = (N_SL > 1) ? $clog2(N_SL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SL - 1);
  localparam logic [R_W-1:0]   R_RST    = R_W'(R_RESET_OHM << R_FRAC);

  state_t state_reg, state_next;

  logic [IDX_W-1:0]        idx_reg;
  logic [N_SL*IN_W-1:0]    frame_reg;
  logic [R_W-1:0]          shadow_r_reg;
  logic [R_W-1:0]          active_r_reg;
  logic signed [OUT_W-1:0] out_v_reg [N_SL];
  logic signed [IN_W-1:0]  frame_sl [N_SL];

  logic                    in_ready_c, out_valid_c, busy_c, calc_en;
  logic                    accept, last_slice;
  logic [IDX_W-1:0]        src_idx;
  logic signed [IN_W-1:0]  mac_cur;
  logic signed [OUT_W-1:0] mac_v;
  logic                    mac_sat;

  assign accept     = in_ready_c & bus.in_valid;
  assign last_slice = (idx_reg == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state: accept a frame, walk all slices, hold until consumed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = CALC;
      CALC:    if (last_slice)    state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    calc_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
      end
      CALC:    calc_en     = 1'b1;
      HOLD:    out_valid_c = 1'b1;
      default: busy_c      = 1'b0;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;

  // Shadow resistance follows r_load in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shadow_r_reg <= R_RST;
    else if (bus.r_load)
      shadow_r_reg <= bus.r_in;
  end

  // Frame capture, active resistance and slice index. A load arriving in
  // the accept cycle bypasses the shadow so that frame already uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg    <= '0;
      active_r_reg <= R_RST;
      idx_reg      <= '0;
    end else if (accept) begin
      frame_reg    <= bus.in_i;
      active_r_reg <= bus.r_load ? bus.r_in : shadow_r_reg;
      idx_reg      <= '0;
    end else if (calc_en) begin
      idx_reg      <= idx_reg + IDX_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SL; gi++) begin : g_frame
      assign frame_sl[gi] = frame_reg[gi*IN_W +: IN_W];
    end
  endgenerate

  // Even slice (v1) uses i2 of the pair and is negated; odd slice (v2) uses i1.
  always_comb begin
    src_idx = idx_reg ^ IDX_W'(1);
    mac_cur = frame_sl[src_idx];
  end

  gyr_mac_sat #(
    .IN_W   (IN_W),
    .R_W    (R_W),
    .R_FRAC (R_FRAC),
    .OUT_W  (OUT_W)
  ) u_mac (
    .cur (mac_cur),
    .r   (active_r_reg),
    .neg (~idx_reg[0]),
    .v   (mac_v),
    .sat (mac_sat)
  );

  generate
    for (gi = 0; gi < N_SL; gi++) begin : g_out
      // Output slice register, written in the CALC cycle that addresses it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          out_v_reg[gi] <= '0;
        else if (calc_en && (idx_reg == IDX_W'(gi)))
          out_v_reg[gi] <= mac_v;
      end
      assign bus.out_v[gi*OUT_W +: OUT_W] = out_v_reg[gi];
    end
  endgenerate

`ifdef GYRATOR_OVF_STICKY_EN
  logic ovf_reg;

  // Sticky saturation flag; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (ovf_clr)
      ovf_reg <= 1'b0;
    else if (calc_en && mac_sat)
      ovf_reg <= 1'b1;
  end

  assign ovf = ovf_reg;
`else
  logic unused_sat;
  assign unused_sat = mac_sat;
`endif

endmodule
